// File: rtl/reg_arbiter_4.sv
// Two-requester round-robin write arbiter in front of a small register bank.
// A grant occupies one GNT cycle; the granted write commits on the edge that leaves GNT.
module reg_arbiter_4 #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       waddr0,
  input  logic [1:0]       waddr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  input  logic [1:0]       raddr,
  output logic [WIDTH-1:0] rdata,
  output logic [3:0]       conflict_cnt
);

  typedef enum logic {IDLE = 1'b0, GNT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] bank_q [NREG];
  logic [WIDTH-1:0] bank_d [NREG];
  logic             win1;

  // ptr_q holds the last-granted requester; on contention the other side wins.
  assign win1 = req1 & (~req0 | ~ptr_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      bank_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = GNT;
          ptr_d   = win1;
        end
        if (req0 && req1 && cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
      end
      GNT: begin
        state_d = IDLE;
        if (ptr_q) bank_d[waddr1] = wdata1;
        else       bank_d[waddr0] = wdata0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants decode purely from flops, so they are clean one-cycle pulses.
  always_comb begin
    busy         = (state_q == GNT);
    gnt0         = busy & ~ptr_q;
    gnt1         = busy &  ptr_q;
    rdata        = bank_q[raddr];
    conflict_cnt = cnt_q;
  end

endmodule

// File: tb/tb_reg_arbiter_4.sv
// Directed bench for reg_arbiter_4: grants go through a scoreboard queue checked by
// a negedge monitor; bank contents and counters are checked inline.
module tb_reg_arbiter_4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [1:0]       waddr0, waddr1, raddr;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, busy;
  logic [WIDTH-1:0] rdata;
  logic [3:0]       conflict_cnt;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic prev_g = 1'b0;

  reg_arbiter_4 #(.WIDTH(WIDTH), .NREG(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .raddr(raddr), .rdata(rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [WIDTH-1:0] exp, input string name);
    raddr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  // Monitor: every observed grant must match the next queued expectation.
  always @(negedge clk) begin
    if (gnt0 || gnt1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got gnt0=%b gnt1=%b, required no grant", gnt0, gnt1);
      end else begin
        int w;
        w = exp_q.pop_front();
        chk("grant_who", {31'd0, gnt1}, w);
        chk("grant_onehot", {31'd0, gnt0 & gnt1}, 0);
        chk("grant_busy", {31'd0, busy}, 1);
        chk("grant_spacing", {31'd0, prev_g}, 0);
      end
    end
    prev_g = gnt0 | gnt1;
  end

  initial begin
    rst = 1'b0; req0 = 0; req1 = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; raddr = 0;

    // Reset, then idle with no requests
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", conflict_cnt, 0);
    for (int a = 0; a < 4; a++) rd(a[1:0], 4'h0, "rst_rdata");

    // Single write from requester 0
    req0 = 1; waddr0 = 2; wdata0 = 4'hF; exp_q.push_back(0);
    cyc();
    chk("single_gnt0", gnt0, 1);
    chk("single_busy", busy, 1);
    req0 = 0;
    cyc();
    chk("single_gnt0_off", gnt0, 0);
    chk("single_busy_off", busy, 0);
    rd(2'd2, 4'hF, "single_rdata2");
    rd(2'd0, 4'h0, "single_rdata0");
    rd(2'd1, 4'h0, "single_rdata1");
    rd(2'd3, 4'h0, "single_rdata3");

    // Contention right after reset: requester 0 first, then alternate
    rst = 0; cyc(); rst = 1;
    req0 = 1; req1 = 1; waddr0 = 0; wdata0 = 4'h5; waddr1 = 1; wdata1 = 4'hA;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("contend_cnt", conflict_cnt, (i + 1) / 2);
    end
    req0 = 0; req1 = 0;
    rd(2'd0, 4'h5, "contend_bank0");
    rd(2'd1, 4'hA, "contend_bank1");

    // Saturation: 40 more cycles of contention, count pins at F
    req0 = 1; req1 = 1;
    for (int k = 0; k < 20; k++) exp_q.push_back(k % 2);
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 30 || i == 40) chk("sat_cnt", conflict_cnt, 4'hF);
    end
    req0 = 0; req1 = 0;

    // Reset during a req1 grant suppresses its write
    rst = 0; cyc(); rst = 1;
    req1 = 1; waddr1 = 3; wdata1 = 4'h7; exp_q.push_back(1);
    cyc();
    chk("midrst_gnt1_pre", gnt1, 1);
    rst = 0;
    cyc();
    chk("midrst_gnt1", gnt1, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", conflict_cnt, 0);
    rd(2'd3, 4'h0, "midrst_bank3");
    rst = 1;
    req0 = 1; waddr0 = 0; wdata0 = 4'h3; exp_q.push_back(0);
    cyc();
    chk("postrst_gnt0", gnt0, 1);
    chk("postrst_gnt1", gnt1, 0);
    req0 = 0; req1 = 0;
    cyc();
    rd(2'd0, 4'h3, "postrst_bank0");
    rd(2'd3, 4'h0, "postrst_bank3");

    // Late request during a grant is dropped
    req0 = 1; waddr0 = 1; wdata0 = 4'h6; exp_q.push_back(0);
    cyc();
    req0 = 0; req1 = 1; waddr1 = 2; wdata1 = 4'hC;
    cyc();
    req1 = 0;
    cyc(); cyc(); cyc();
    chk("late_busy", busy, 0);
    rd(2'd1, 4'h6, "late_bank1");
    rd(2'd2, 4'h0, "late_bank2");

    cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
